act_skew_feeder: RTL and testbench
==================================

Name: act_skew_feeder

Overview:
- Upstream stage of the systolic PE array: accepts one activation vector per beat (one lane per array row) over a valid/ready stream and drives each row's leftmost PE activation input.
- Row r is delayed by r cycles, producing the diagonal wavefront the array requires.
- Tracks tile boundaries, throttles the source while the skew drains, and flags completion of the last row.

Parameters:
- DATA_W, 8, activation width per lane (matches PE activation width).
- ROWS, 4, number of array rows / lanes (≥1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  source beat valid.
- s_ready  output  1  feeder can accept a beat.
- s_data  input  ROWS*DATA_W  activation vector; lane r = bits [r*DATA_W +: DATA_W].
- s_last  input  1  beat is final of tile; qualified by s_valid&&s_ready.
- out_act  output  ROWS*DATA_W  per-row activation to column-0 PEs; lane r drives row r.
- out_valid  output  ROWS  per-row valid to PE valid_in.
- busy  output  1  state≠IDLE or any out_valid/internal stage valid set.
- done  output  1  one-cycle pulse when row ROWS-1 presents the tile's last beat.

Behaviour:
- Reset (async, any time, including mid-tile): all skew stages, out_act, out_valid, done cleared to 0; state IDLE; flush counter 0; s_ready=1 after reset deasserts.
- Lane r is a register chain of depth r+1 carrying {data, valid}; lane ROWS-1 also carries a last flag. The chain shifts every clock, unconditionally.
- Accept = s_valid && s_ready. On an accepting edge t, stage 0 of every lane loads {s_data lane, 1}. Otherwise stage 0 loads {0, 0}.
  - A bubble therefore propagates as data 0, valid 0, and the PE MAC adds nothing.
- Row r output visible after edge t+r, so latency from accepting edge is r cycles after row 0. Back-to-back beats appear on consecutive cycles per row.
- out_act lane r = final stage data of lane r; out_valid[r] = final stage valid; both are registered outputs.
- done = final-stage valid && last of lane ROWS-1. It is asserted in the same cycle as out_valid[ROWS-1] for the last beat.
- FSM:
  - IDLE: s_ready=1. Accept without s_last → STREAM. Accept with s_last → FLUSH (IDLE if ROWS=1).
  - STREAM: s_ready=1. Accept with s_last → FLUSH (IDLE if ROWS=1). Otherwise stay; bubbles are allowed.
  - FLUSH: s_ready=0; flush counter counts 0..ROWS-2, one per edge. At the edge with counter=ROWS-2 → IDLE and counter cleared.
  - The next tile's first beat can be accepted in the cycle done is high. Tiles never interleave in the skew.
- s_last with s_valid low is ignored. s_valid held during FLUSH is not accepted, and the source holds its data.
- Data is passed unmodified; no arithmetic or width change.

Test Plan:
- Reset: assert rst_n=0 mid-clock → out_act=0, out_valid=0, done=0, busy=0 immediately; after release s_ready=1.
- Single-beat tile, ROWS=4: s_data lanes {1,2,3,4}, s_last=1 accepted at edge t.
  - Row0=1 after t, row1=2 after t+1, row2=3 after t+2, row3=4 after t+3.
  - done high only in cycle after t+3; s_ready=0 during the three FLUSH cycles; accept possible again in done cycle.
- Three back-to-back beats {1,2,3,4},{5,6,7,8},{9,10,11,12}, last on third.
  - Row2 shows 3,7,11 on consecutive cycles starting after edge t+2.
  - Row3 shows 4,8,12; done with 12.
- Bubble: beat {10,20,30,40}, idle cycle, beat {50,60,70,80} with last → row1 shows 20, then 0 with out_valid[1]=0, then 60.
- s_valid=1 with data {9,9,9,9} held throughout FLUSH → not accepted until state IDLE; appears on row0 exactly once.
- Reset asserted after two beats of a non-last tile → all outputs 0 immediately. After release, a new single-beat tile completes normally with done after 3 cycles.

Source files
------------

// File: rtl/act_skew_feeder.sv
// act_skew_feeder: skews activation lanes so row r lags row 0 by r cycles and throttles the source while a tile drains.
module act_skew_feeder #(
   parameter int DATA_W = 8,
   parameter int ROWS   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [ROWS*DATA_W-1:0] s_data,
   input  logic                   s_last,
   output logic [ROWS*DATA_W-1:0] out_act,
   output logic [ROWS-1:0]        out_valid,
   output logic                   busy,
   output logic                   done
);
   localparam int CW = ROWS > 1 ? $clog2(ROWS) : 1;
   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [ROWS-1:0] r_last;
   logic [ROWS-1:0] w_any;
   logic            w_acc;
   logic            w_cnt_end;
   assign w_acc     = s_valid && s_ready;
   assign w_cnt_end = r_cnt == CW'(ROWS - 2);
   assign s_ready   = r_state != FLUSH;
   assign busy      = r_state != IDLE || |w_any;
   assign done      = out_valid[ROWS-1] && r_last[ROWS-1];
   for (genvar g = 0; g < ROWS; g++) begin : g_lane
      logic [DATA_W-1:0] r_d [0:g];
      logic [g:0]        r_v;
      // a bubble enters as data 0 so downstream MACs accumulate nothing
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            for (int i = 0; i <= g; i++) r_d[i] <= '0;
            r_v <= '0;
         end else begin
            r_d[0] <= w_acc ? s_data[g*DATA_W +: DATA_W] : '0;
            for (int i = 1; i <= g; i++) r_d[i] <= r_d[i-1];
            r_v <= (r_v << 1) | (g+1)'(w_acc);
         end
      assign out_act[g*DATA_W +: DATA_W] = r_d[g];
      assign out_valid[g]                = r_v[g];
      assign w_any[g]                    = |r_v;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_last <= '0;
      else        r_last <= (r_last << 1) | ROWS'(w_acc && s_last);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else if (r_state == FLUSH) begin
         r_cnt <= w_cnt_end ? '0 : r_cnt + CW'(1);
         if (w_cnt_end) r_state <= IDLE;
      end else if (w_acc) begin
         r_state <= s_last ? (ROWS == 1 ? IDLE : FLUSH) : STREAM;
      end
endmodule

// File: tb/tb_act_skew_feeder.sv
// tb_act_skew_feeder: directed and random beats checked against a cycle-history model of the skew feeder.
module tb_act_skew_feeder;
   localparam int DATA_W = 8;
   localparam int ROWS   = 4;
   localparam int W      = ROWS * DATA_W;
   localparam int HN     = 4096;
   logic          clk;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  s_data;
   logic          s_last;
   logic [W-1:0]  out_act;
   logic [ROWS-1:0] out_valid;
   logic          busy;
   logic          done;
   int            n_cmp;
   int            n_err;
   int            n;
   int            rst_cycle;
   int            last_edge;
   logic          in_tile;
   logic          last_acc;
   logic          hv [HN];
   logic          hl [HN];
   logic [W-1:0]  hd [HN];
   act_skew_feeder #(.DATA_W(DATA_W), .ROWS(ROWS)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .out_act(out_act), .out_valid(out_valid), .busy(busy), .done(done)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic logic [W-1:0] pack(input int a, input int b, input int c, input int d);
      return {d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction
   // the source may be accepted unless a last beat was taken within the previous ROWS-1 edges
   function automatic logic exp_ready();
      return !(n - last_edge <= ROWS - 2);
   endfunction
   function automatic logic hist_v(input int e);
      return e > rst_cycle && e >= 0 && hv[e];
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
      end
   endtask
   task automatic check_outputs();
      logic [W-1:0]    e_act;
      logic [ROWS-1:0] e_vld;
      logic            e_done;
      logic            e_busy;
      e_act  = '0;
      e_vld  = '0;
      e_busy = !exp_ready() || in_tile;
      for (int r = 0; r < ROWS; r++) begin
         if (hist_v(n - r)) begin
            e_act[r*DATA_W +: DATA_W] = hd[n-r][r*DATA_W +: DATA_W];
            e_vld[r] = 1'b1;
            e_busy   = 1'b1;
         end
      end
      e_done = hist_v(n - (ROWS - 1)) && hl[n-(ROWS-1)];
      chk("out_act", 64'(out_act), 64'(e_act));
      chk("out_valid", 64'(out_valid), 64'(e_vld));
      chk("done", 64'(done), 64'(e_done));
      chk("busy", 64'(busy), 64'(e_busy));
   endtask
   task automatic step(input logic v, input logic [W-1:0] d, input logic l);
      s_valid = v;
      s_data  = d;
      s_last  = l;
      #1;
      chk("s_ready", 64'(s_ready), 64'(exp_ready()));
      last_acc = v && exp_ready();
      @(posedge clk);
      n++;
      hv[n] = last_acc;
      hd[n] = last_acc ? d : '0;
      hl[n] = last_acc && l;
      if (last_acc) begin
         if (l) begin
            last_edge = n;
            in_tile   = 1'b0;
         end else in_tile = 1'b1;
      end
      #1;
      check_outputs();
   endtask
   task automatic mid_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_act", 64'(out_act), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      s_valid = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
      rst_n     = 1'b1;
      rst_cycle = n;
      last_edge = -1000;
      in_tile   = 1'b0;
      #1;
      chk("rst_ready", 64'(s_ready), 64'd1);
   endtask
   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(1'b0, '0, 1'b0);
   endtask
   initial begin
      int nines;
      int hold;
      n_cmp = 0; n_err = 0; n = 0; rst_cycle = 0; last_edge = -1000; in_tile = 1'b0;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0; rst_n = 1'b0;
      for (int i = 0; i < HN; i++) begin hv[i] = 1'b0; hl[i] = 1'b0; hd[i] = '0; end
      repeat (2) @(posedge clk);
      #1;
      chk("init_act", 64'(out_act), 64'd0);
      chk("init_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      step(1'b1, pack(1, 2, 3, 4), 1'b1);
      step(1'b1, pack(5, 6, 7, 8), 1'b0);
      step(1'b1, pack(5, 6, 7, 8), 1'b0);
      step(1'b1, pack(5, 6, 7, 8), 1'b0);
      step(1'b1, pack(5, 6, 7, 8), 1'b0);
      step(1'b1, pack(9, 10, 11, 12), 1'b0);
      step(1'b1, pack(13, 14, 15, 16), 1'b1);
      idle(5);
      step(1'b1, pack(10, 20, 30, 40), 1'b0);
      step(1'b0, pack(99, 99, 99, 99), 1'b1);
      step(1'b1, pack(50, 60, 70, 80), 1'b1);
      idle(5);
      step(1'b1, pack(1, 2, 3, 4), 1'b1);
      nines = 0;
      hold  = 0;
      do begin
         step(1'b1, pack(9, 9, 9, 9), 1'b0);
         hold++;
         if (out_valid[0] && out_act[7:0] == 8'd9) nines++;
      end while (!last_acc && hold < 10);
      chk("hold_steps", 64'(hold), 64'd4);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, 1'b0);
         if (out_valid[0] && out_act[7:0] == 8'd9) nines++;
      end
      chk("row0_nines", 64'(nines), 64'd1);
      step(1'b1, pack(7, 7, 7, 7), 1'b1);
      idle(4);
      step(1'b1, pack(21, 22, 23, 24), 1'b0);
      step(1'b1, pack(25, 26, 27, 28), 1'b0);
      mid_reset();
      step(1'b1, pack(31, 32, 33, 34), 1'b1);
      idle(5);
      for (int i = 0; i < 400; i++) begin
         if (i == 200) mid_reset();
         step($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 4) == 0);
      end
      idle(6);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
